flow_bucket_lookup: RTL and testbench
=====================================

# flow_bucket_lookup

Direct-mapped flow-table lookup and insert stage that consumes the `hashed`/`hashed_valid` stream of the Lookup3 hash unit. The low `IDX_W` bits of the hash select one bucket of an internal table; the bucket's stored 96-bit key is compared against the accompanying tuple. The block reports hit, insert, or collision for each request, optionally inserting misses into empty buckets. It sits directly after the hash unit in the flow-tracking path and shares its `stall` freeze semantics.

## Interface
- `IDX_W`, default 10: bucket index width; table depth is `DEPTH = 2**IDX_W`. Legal range 2..14.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  freezes every pipeline register and suppresses table writes; does not freeze the clear sweep.
- `hashed`  in  32  hash value; bucket index = `hashed[IDX_W-1:0]`.
- `hashed_valid`  in  1  request valid.
- `tuple_in`  in  `tuple_t`  flow tuple aligned with `hashed`; key = `{sIP, sPort, dIP, dPort}` (96 bits).
- `insert_en`  in  1  sampled with the request; 1 = insert on miss into an empty bucket.
- `ready`  out  1  0 while the table is being cleared; requests presented while `ready=0` are dropped.
- `out_valid`  out  1  result valid.
- `out_tuple`  out  `tuple_t`  request tuple echoed.
- `out_idx`  out  `IDX_W`  bucket index used.
- `out_hit`  out  1  bucket valid and key equal.
- `out_inserted`  out  1  miss, bucket empty, `insert_en=1`; the key was written.
- `out_collision`  out  1  bucket valid with a different key.

## Operation
- Table entry: `{vld, key[95:0]}`, held in a simple dual-port RAM. Reads have 1-cycle registered latency. A read during a write to the same address returns the old data.
- Pipeline stages, all advancing only when `stall=0`:
  - S0 captures the request and issues the RAM read at the index.
  - S1 waits on the RAM read.
  - S2 selects the bucket data (with forwarding), compares, and decides the result and any write.
  - S3 is the output register.
- Exactly one of `out_hit`, `out_inserted`, `out_collision` may be 1 when `out_valid=1`. All three are 0 on a plain miss (empty bucket, `insert_en=0`).
- The write on insert is issued from S2 on the same edge that advances S2 into S3.
- Forwarding: S2 keeps the last two insert writes it performed, as (idx, key) pairs. If S2's index matches one of them, the youngest matching pair replaces the RAM data (`vld=1`). Back-to-back requests to the same bucket therefore see earlier inserts. For example, two identical inserts on consecutive cycles yield inserted then hit.
- Clear sweep:
  - After `rst` deasserts, a counter writes `vld=0` to entries 0..DEPTH-1, one per cycle, regardless of `stall`.
  - `ready=1` only after the sweep finishes.
  - S0 accepts requests only when `ready=1`.
- When `stall=1`, outputs hold their previous values, including `out_valid=1` if it was 1. Consumers must not double-count a result held by stall.

## Timing
- Latency: a request accepted at edge t (with `hashed_valid=1`, `ready=1`, `stall=0`) produces `out_valid=1` after edge t+3. Each stalled cycle adds one.
- Throughput: one request per cycle, no bubbles, including same-bucket back-to-back requests.
- Reset values: `ready=0`, `out_valid=0`, `out_hit=0`, `out_inserted=0`, `out_collision=0`, `out_idx=0`, `out_tuple=0`. The S0–S2 valid bits and the forwarding-history valid bits are 0.
- `ready` is 0 for exactly DEPTH cycles after the first edge with `rst=0`, then stays 1 until the next reset.
- Reset mid-operation: any edge with `rst=1` discards in-flight requests (no output, no write) and clears forwarding history. The sweep restarts at entry 0 once `rst` drops.
- `stall=1` during the sweep: the sweep continues. A request held by `stall` in S0 as `ready` rises is not affected.

## Test plan
- Reset and clear with `IDX_W=4`: after `rst` drops, `ready` stays 0 for 16 cycles then goes 1. The first lookup of hash 0x5 returns `out_valid=1` with hit, inserted and collision all 0.
- Insert then lookup: tuple A, hash 0x0000_0003, `insert_en=1` -> `out_inserted=1`, `out_idx=3`. Five cycles later A with `insert_en=0` -> `out_hit=1`.
- Collision: after A is in bucket 3, tuple B with hash 0x0000_0013 and `insert_en=1` -> `out_collision=1`, no write. A subsequent lookup of A still gives `out_hit=1`.
- Forwarding: A then A on consecutive cycles, both `insert_en=1`, hash 0x7 -> inserted then hit. A, C, A with gaps of 0 to a shared bucket -> inserted, collision, hit.
- Stall: assert `stall` for 4 cycles while 2 requests are in flight -> outputs frozen, no extra results. Release -> results appear in order, total latency 3+4.
- Mid-operation reset: pulse `rst` for 1 cycle with 3 requests in flight -> no `out_valid`, `ready` low for 16 cycles. The earlier inserted A then returns a miss.

Source files
------------

// File: rtl/flow_bucket_lookup.sv
// Direct-mapped flow-table lookup/insert stage behind the hash unit; 3-cycle latency plus stalled cycles.
// stall freezes the pipeline and blocks inserts; the post-reset clear sweep runs regardless and drops requests until ready.
package flow_bucket_lookup_pkg;
    typedef struct packed {
        logic [31:0] sIP;
        logic [15:0] sPort;
        logic [31:0] dIP;
        logic [15:0] dPort;
    } tuple_t;
endpackage

module flow_bucket_lookup
    import flow_bucket_lookup_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      hashed,
    input  logic             hashed_valid,
    input  tuple_t           tuple_in,
    input  logic             insert_en,
    output logic             ready,
    output logic             out_valid,
    output tuple_t           out_tuple,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_hit,
    output logic             out_inserted,
    output logic             out_collision
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int KEY_W = $bits(tuple_t);

    // Table entry layout: {vld, key}
    logic [KEY_W:0]     mem_q [DEPTH];
    logic [KEY_W:0]     rd_q;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_addr;
    logic [KEY_W:0]     wr_dat;

    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               ready_q, ready_d;

    logic               s0_vld_q, s1_vld_q, s2_vld_q;
    logic [IDX_W-1:0]   s0_idx_q, s1_idx_q, s2_idx_q;
    tuple_t             s0_tuple_q, s1_tuple_q, s2_tuple_q;
    logic               s0_ins_q, s1_ins_q, s2_ins_q;
    logic [KEY_W:0]     s2_bkt_q;

    logic [1:0]         hist_vld_q;
    logic [IDX_W-1:0]   hist_idx_q [2];
    logic [KEY_W-1:0]   hist_key_q [2];

    logic               fwd_vld;
    logic [KEY_W-1:0]   fwd_key;
    logic               hit_d, ins_d, col_d;

    logic               out_valid_q, out_hit_q, out_ins_q, out_col_q;
    logic [IDX_W-1:0]   out_idx_q;
    tuple_t             out_tuple_q;

    logic               hash_unused;
    assign hash_unused = ^hashed[31:IDX_W];

    always_comb begin
        ready_d   = ready_q;
        clr_idx_d = clr_idx_q;
        if (!ready_q) begin
            clr_idx_d = clr_idx_q + 1'b1;
            ready_d   = &clr_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    // Sweep owns the write port until ready; S2 never holds a request then.
    always_comb begin
        wr_en   = !rst && (!ready_q || (ins_d && !stall));
        wr_addr = ready_q ? s2_idx_q : clr_idx_q;
        wr_dat  = ready_q ? {1'b1, KEY_W'(s2_tuple_q)} : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_addr] <= wr_dat;
        if (!stall)
            rd_q <= mem_q[s0_idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_q <= 1'b0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else if (!stall) begin
            s0_vld_q <= hashed_valid && ready_q;
            s1_vld_q <= s0_vld_q;
            s2_vld_q <= s1_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            s0_idx_q   <= hashed[IDX_W-1:0];
            s0_tuple_q <= tuple_in;
            s0_ins_q   <= insert_en;
            s1_idx_q   <= s0_idx_q;
            s1_tuple_q <= s0_tuple_q;
            s1_ins_q   <= s0_ins_q;
            s2_idx_q   <= s1_idx_q;
            s2_tuple_q <= s1_tuple_q;
            s2_ins_q   <= s1_ins_q;
            s2_bkt_q   <= rd_q;
        end
    end

    // The RAM read predates the last two S2 inserts; slot 0 is the youngest and wins.
    always_comb begin
        fwd_vld = s2_bkt_q[KEY_W];
        fwd_key = s2_bkt_q[KEY_W-1:0];
        if (hist_vld_q[1] && hist_idx_q[1] == s2_idx_q) begin
            fwd_vld = 1'b1;
            fwd_key = hist_key_q[1];
        end
        if (hist_vld_q[0] && hist_idx_q[0] == s2_idx_q) begin
            fwd_vld = 1'b1;
            fwd_key = hist_key_q[0];
        end
        hit_d = s2_vld_q && fwd_vld && (fwd_key == KEY_W'(s2_tuple_q));
        col_d = s2_vld_q && fwd_vld && (fwd_key != KEY_W'(s2_tuple_q));
        ins_d = s2_vld_q && !fwd_vld && s2_ins_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_vld_q <= 2'b00;
        end else if (ins_d && !stall) begin
            hist_vld_q <= {hist_vld_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (ins_d && !stall) begin
            hist_idx_q[1] <= hist_idx_q[0];
            hist_key_q[1] <= hist_key_q[0];
            hist_idx_q[0] <= s2_idx_q;
            hist_key_q[0] <= KEY_W'(s2_tuple_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_ins_q   <= 1'b0;
            out_col_q   <= 1'b0;
            out_idx_q   <= '0;
            out_tuple_q <= '0;
        end else if (!stall) begin
            out_valid_q <= s2_vld_q;
            out_hit_q   <= hit_d;
            out_ins_q   <= ins_d;
            out_col_q   <= col_d;
            out_idx_q   <= s2_idx_q;
            out_tuple_q <= s2_tuple_q;
        end
    end

    assign ready         = ready_q;
    assign out_valid     = out_valid_q;
    assign out_hit       = out_hit_q;
    assign out_inserted  = out_ins_q;
    assign out_collision = out_col_q;
    assign out_idx       = out_idx_q;
    assign out_tuple     = out_tuple_q;
endmodule

// File: tb/tb_flow_bucket_lookup.sv
// Bench for flow_bucket_lookup: sequential table model with stall-aware timing, directed scenarios and random traffic.
module tb_flow_bucket_lookup;
    import flow_bucket_lookup_pkg::*;

    localparam int IDX_W = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic [31:0]      hashed;
    logic             hashed_valid;
    tuple_t           tuple_in;
    logic             insert_en;
    logic             ready;
    logic             out_valid;
    tuple_t           out_tuple;
    logic [IDX_W-1:0] out_idx;
    logic             out_hit;
    logic             out_inserted;
    logic             out_collision;

    always #5 clk = ~clk;

    flow_bucket_lookup #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .hashed(hashed), .hashed_valid(hashed_valid),
        .tuple_in(tuple_in), .insert_en(insert_en),
        .ready(ready), .out_valid(out_valid), .out_tuple(out_tuple),
        .out_idx(out_idx), .out_hit(out_hit),
        .out_inserted(out_inserted), .out_collision(out_collision)
    );

    typedef struct {
        int unsigned adv;
        logic [3:0]  idx;
        tuple_t      tup;
        bit          hit;
        bit          ins;
        bit          col;
    } exp_t;

    int     tests = 0;
    int     fails = 0;
    bit     m_vld [DEPTH];
    tuple_t m_key [DEPTH];
    exp_t   q [$];
    exp_t   cur;
    bit     cur_vld = 0;
    bit     res_new = 0;
    int unsigned adv_cnt = 0;
    int     sweep_cnt = 0;
    int     cyc = 0;
    int     last_acc = 0;
    int     found_cyc = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: requests resolve strictly in acceptance order against a plain array;
    // results emerge after 3 unstalled edges.
    always @(posedge clk) begin
        cyc++;
        res_new = 0;
        if (rst) begin
            q.delete();
            cur_vld = 0;
            cur.idx = '0; cur.tup = '0; cur.hit = 0; cur.ins = 0; cur.col = 0;
            sweep_cnt = 0;
            foreach (m_vld[i]) m_vld[i] = 0;
        end else begin
            if (!stall) begin
                adv_cnt++;
                if (hashed_valid && sweep_cnt >= DEPTH) begin
                    exp_t e;
                    e.adv = adv_cnt + 3;
                    e.idx = hashed[3:0];
                    e.tup = tuple_in;
                    e.hit = m_vld[e.idx] && m_key[e.idx] == tuple_in;
                    e.col = m_vld[e.idx] && m_key[e.idx] != tuple_in;
                    e.ins = !m_vld[e.idx] && insert_en;
                    if (e.ins) begin
                        m_vld[e.idx] = 1;
                        m_key[e.idx] = tuple_in;
                    end
                    q.push_back(e);
                end
                if (q.size() > 0 && q[0].adv == adv_cnt) begin
                    cur = q.pop_front();
                    cur_vld = 1;
                    res_new = 1;
                end else begin
                    cur_vld = 0;
                end
            end
            if (sweep_cnt < DEPTH) sweep_cnt++;
        end
    end

    always @(negedge clk) begin
        chk("ready", ready, sweep_cnt >= DEPTH);
        chk("out_valid", out_valid, cur_vld);
        if (cur_vld) begin
            chk("out_idx", out_idx, cur.idx);
            chk("out_tuple", out_tuple, cur.tup);
            chk("out_hit", out_hit, cur.hit);
            chk("out_inserted", out_inserted, cur.ins);
            chk("out_collision", out_collision, cur.col);
        end
    end

    task automatic send(input logic [31:0] h, input tuple_t t, input bit ie);
        hashed = h; tuple_in = t; insert_en = ie; hashed_valid = 1;
        last_acc = cyc + 1;
        @(negedge clk);
        hashed_valid = 0;
    endtask

    task automatic expect_res(input string nm, input bit h, input bit i, input bit c, input logic [3:0] idx);
        int n = 0;
        bit got = 0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (out_valid && res_new) got = 1;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s: timeout, got no result, expected one", nm);
        end else begin
            found_cyc = cyc;
            chk({nm, "_hit"}, out_hit, h);
            chk({nm, "_ins"}, out_inserted, i);
            chk({nm, "_col"}, out_collision, c);
            chk({nm, "_idx"}, out_idx, idx);
        end
    endtask

    task automatic count_clear(input string nm);
        int n = 0;
        bit seen = 0;
        while (!ready && n < 40) begin
            if (out_valid) seen = 1;
            n++;
            @(negedge clk);
        end
        chk(nm, n, 16);
        chk({nm, "_no_out"}, seen, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected one");
        $fatal(1);
    end

    initial begin
        tuple_t A, B, C, D, X;
        tuple_t pool [4];
        int acc;
        A = '{sIP:32'h0a000001, sPort:16'd1000, dIP:32'h0a000002, dPort:16'd80};
        B = '{sIP:32'h0a000003, sPort:16'd2000, dIP:32'h0a000004, dPort:16'd443};
        C = '{sIP:32'hc0a80001, sPort:16'd3000, dIP:32'hc0a80002, dPort:16'd53};
        D = '{sIP:32'h08080808, sPort:16'd4000, dIP:32'h01010101, dPort:16'd22};
        foreach (pool[i]) pool[i] = '{sIP:$urandom, sPort:16'($urandom), dIP:$urandom, dPort:16'($urandom)};
        pool[0] = A;

        rst = 1; stall = 0; hashed = '0; hashed_valid = 0; tuple_in = '0; insert_en = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {out_hit, out_inserted, out_collision}, 3'b000);
        chk("rst_idx", out_idx, 0);
        chk("rst_tuple", out_tuple, 0);
        rst = 0;
        count_clear("clear_init");

        send(32'h5, B, 0);
        expect_res("first_lookup", 0, 0, 0, 4'h5);

        repeat (3) @(negedge clk);
        send(32'h3, A, 1);
        expect_res("ins_A", 0, 1, 0, 4'h3);
        send(32'h3, A, 0);
        expect_res("lookup_A", 1, 0, 0, 4'h3);

        send(32'h13, B, 1);
        expect_res("collide_B", 0, 0, 1, 4'h3);
        send(32'h3, A, 0);
        expect_res("lookup_A_again", 1, 0, 0, 4'h3);

        send(32'h7, A, 1);
        send(32'h7, A, 1);
        expect_res("fwd_ins", 0, 1, 0, 4'h7);
        expect_res("fwd_hit", 1, 0, 0, 4'h7);

        send(32'h9, A, 1);
        send(32'h9, C, 1);
        send(32'h9, A, 0);
        expect_res("fwd2_ins", 0, 1, 0, 4'h9);
        expect_res("fwd2_col", 0, 0, 1, 4'h9);
        expect_res("fwd2_hit", 1, 0, 0, 4'h9);

        repeat (4) @(negedge clk);
        send(32'hA, D, 1);
        acc = last_acc;
        send(32'hA, D, 0);
        stall = 1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_frozen", out_valid, 0);
        end
        stall = 0;
        expect_res("stall_ins", 0, 1, 0, 4'hA);
        chk("stall_latency", found_cyc - acc, 7);
        expect_res("stall_hit", 1, 0, 0, 4'hA);

        repeat (4) @(negedge clk);
        send(32'hC, B, 1);
        send(32'hD, C, 1);
        send(32'hE, D, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        count_clear("clear_mid");
        send(32'h3, A, 0);
        expect_res("A_after_reset", 0, 0, 0, 4'h3);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] h;
            h = $urandom;
            h[3:0] = 4'($urandom_range(0, 15));
            hashed = h;
            tuple_in = pool[$urandom_range(0, 3)];
            insert_en = 1'($urandom);
            hashed_valid = ($urandom_range(0, 2) != 0);
            stall = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        X = '0;
        rst = 0; stall = 0; hashed_valid = 0; tuple_in = X;
        repeat (25) @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
